// File: rtl/cpu_cu.sv
// Multi-cycle control unit for the 16-bit RISC core: fetch, decode, execute with MEM_WAIT wait states.
// Define CPU_CU_STEP_EN to add a single-step input that gates entry to every fetch.
module cpu_cu #(
  parameter int unsigned MEM_WAIT   = 0,
  parameter logic [3:0]  ALU_PASS_R = 4'h0,
  parameter logic [3:0]  ALU_PASS_S = 4'h1
) (
  input  logic        clk,
  input  logic        reset,
`ifdef CPU_CU_STEP_EN
  input  logic        step,
`endif
  input  logic [15:0] ir_in,
  input  logic        C,
  input  logic        N,
  input  logic        Z,
  output logic        w_en,
  output logic        s_sel,
  output logic        adr_sel,
  output logic        pc_ld,
  output logic        pc_inc,
  output logic        pc_sel,
  output logic        ir_ld,
  output logic [2:0]  W_Adr,
  output logic [2:0]  R_Adr,
  output logic [2:0]  S_Adr,
  output logic [3:0]  ALU_OP,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [2:0]  psr,
  output logic        halted,
  output logic        illegal,
  output logic [3:0]  dbg_state
);

  localparam logic [3:0] ST_RST       = 4'd0;
  localparam logic [3:0] ST_FETCH     = 4'd1;
  localparam logic [3:0] ST_DECODE    = 4'd2;
  localparam logic [3:0] ST_EX_ALU    = 4'd3;
  localparam logic [3:0] ST_EX_LD     = 4'd4;
  localparam logic [3:0] ST_EX_ST     = 4'd5;
  localparam logic [3:0] ST_EX_LDI    = 4'd6;
  localparam logic [3:0] ST_EX_BR     = 4'd7;
  localparam logic [3:0] ST_EX_JR     = 4'd8;
  localparam logic [3:0] ST_HALT      = 4'd9;
  localparam logic [3:0] ST_ILLEGAL   = 4'd10;
  localparam logic [3:0] ST_STEP_WAIT = 4'd11;

  localparam logic [3:0] WAIT_LAST = MEM_WAIT[3:0];

  logic [3:0] state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [2:0] psr_q, psr_d;
  logic [6:0] op;
  logic       last_cyc;
  logic       go_step;
  logic       br_taken;
  logic [3:0] after_ex;

  assign op       = ir_in[15:9];
  assign last_cyc = (cnt_q == WAIT_LAST);

`ifdef CPU_CU_STEP_EN
  assign go_step  = step;
  assign after_ex = ST_STEP_WAIT;
`else
  assign go_step  = 1'b1;
  assign after_ex = ST_FETCH;
`endif

  // Branch conditions use the flags latched by the last ALU instruction, never the live ones.
  always_comb begin
    br_taken = 1'b0;
    case (op)
      7'h20:   br_taken = 1'b1;
      7'h21:   br_taken = psr_q[0];
      7'h22:   br_taken = ~psr_q[0];
      7'h23:   br_taken = psr_q[2];
      7'h24:   br_taken = psr_q[1];
      default: br_taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = 4'd0;
    psr_d   = psr_q;
    case (state_q)
      ST_RST, ST_STEP_WAIT: state_d = go_step ? ST_FETCH : state_q;
      ST_FETCH: begin
        if (last_cyc) state_d = ST_DECODE;
        else          cnt_d   = cnt_q + 4'd1;
      end
      ST_DECODE: begin
        if (op[6:4] == 3'b000) begin
          state_d = ST_EX_ALU;
        end else begin
          case (op)
            7'h10:                             state_d = ST_EX_LD;
            7'h11:                             state_d = ST_EX_ST;
            7'h12:                             state_d = ST_EX_LDI;
            7'h20, 7'h21, 7'h22, 7'h23, 7'h24: state_d = ST_EX_BR;
            7'h28:                             state_d = ST_EX_JR;
            7'h7F:                             state_d = ST_HALT;
            default:                           state_d = ST_ILLEGAL;
          endcase
        end
      end
      ST_EX_ALU: begin
        psr_d   = {C, N, Z};
        state_d = after_ex;
      end
      ST_EX_LD, ST_EX_ST, ST_EX_LDI: begin
        if (last_cyc) state_d = after_ex;
        else          cnt_d   = cnt_q + 4'd1;
      end
      ST_EX_BR, ST_EX_JR:    state_d = after_ex;
      ST_HALT, ST_ILLEGAL:   state_d = state_q;
      default:               state_d = ST_ILLEGAL;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_RST;
      cnt_q   <= 4'd0;
      psr_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      psr_q   <= psr_d;
    end
  end

  // Strobes are decoded from the registered state only, so an async reset drops them at once.
  always_comb begin
    w_en    = 1'b0;
    s_sel   = 1'b0;
    adr_sel = 1'b0;
    pc_ld   = 1'b0;
    pc_inc  = 1'b0;
    pc_sel  = 1'b0;
    ir_ld   = 1'b0;
    ALU_OP  = ALU_PASS_R;
    mem_rd  = 1'b0;
    mem_wr  = 1'b0;
    case (state_q)
      ST_FETCH: begin
        mem_rd = 1'b1;
        ir_ld  = last_cyc;
        pc_inc = last_cyc;
      end
      ST_EX_ALU: begin
        ALU_OP = op[3:0];
        w_en   = 1'b1;
      end
      ST_EX_LD: begin
        adr_sel = 1'b1;
        mem_rd  = 1'b1;
        s_sel   = 1'b1;
        ALU_OP  = ALU_PASS_S;
        w_en    = last_cyc;
      end
      ST_EX_ST: begin
        adr_sel = 1'b1;
        ALU_OP  = ALU_PASS_S;
        mem_wr  = 1'b1;
      end
      ST_EX_LDI: begin
        mem_rd = 1'b1;
        s_sel  = 1'b1;
        ALU_OP = ALU_PASS_S;
        w_en   = last_cyc;
        pc_inc = last_cyc;
      end
      ST_EX_BR: pc_ld = br_taken;
      ST_EX_JR: begin
        pc_sel = 1'b1;
        pc_ld  = 1'b1;
      end
      default: ;
    endcase
  end

  assign W_Adr     = ir_in[8:6];
  assign R_Adr     = ir_in[5:3];
  assign S_Adr     = ir_in[2:0];
  assign psr       = psr_q;
  assign halted    = (state_q == ST_HALT) || (state_q == ST_ILLEGAL);
  assign illegal   = (state_q == ST_ILLEGAL);
  assign dbg_state = state_q;

endmodule
